// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of the instruction-memory request bus, the branch redirect input
// and the decode-side ready/valid head for fetch_prefetch_queue.
// master: the fetch unit. slave: memory, branch unit and decode.
interface fetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ImemReq;
  logic [31:0]   ImemAddr;
  logic          ImemAck;
  logic [31:0]   ImemData;
  logic          Redirect;
  logic [31:0]   RedirectPC;
  logic          DecReady;
  logic          InstrValid;
  logic [31:0]   Instruction;
  logic [31:0]   PCPlus4;
  logic [CW-1:0] Count;

  modport master (
    output ImemReq, ImemAddr, InstrValid, Instruction, PCPlus4, Count,
    input  ImemAck, ImemData, Redirect, RedirectPC, DecReady
  );

  modport slave (
    input  ImemReq, ImemAddr, InstrValid, Instruction, PCPlus4, Count,
    output ImemAck, ImemData, Redirect, RedirectPC, DecReady
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the PC, fetches over a variable-latency
// req/ack bus, buffers words in a DEPTH-entry FIFO popped by decode, and
// flushes on a branch redirect (an in-flight fetch is drained and dropped).
// Optional feature macro: FETCH_PERF_CNT_EN adds FetchCount/FlushCount.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                   FetchCount,
  output logic [31:0]                   FlushCount,
`endif
  fetch_prefetch_queue_if.master        bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,  // no request outstanding
    S_WAIT,  // request outstanding, response will be kept
    S_DROP   // request outstanding, response will be discarded
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] occ_after_pop;
  logic [31:0]   redirect_pc;
  logic [31:0]   next_pc;
  entry_t        head;

  assign redirect_pc   = bus.RedirectPC & ~32'h3;
  assign next_pc       = fetch_pc_q + 32'd4;
  assign pop           = (count_q != '0) && bus.DecReady && !bus.Redirect;
  assign occ_after_pop = count_q - CW'(pop);

  // Fetch FSM: next state, next PC/address and push/flush decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (occ_after_pop < CW'(DEPTH)) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (bus.Redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = bus.ImemAck ? S_IDLE : S_DROP;
        end else if (bus.ImemAck) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          // Only keep requesting if the word after this one has a free slot.
          if (occ_after_pop + CW'(1) < CW'(DEPTH)) begin
            addr_d = next_pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (bus.Redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
        if (bus.ImemAck) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; a flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge Clk) begin
    // NOTE: storage has no reset; entries are only observed through count_q, which is reset.
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: bus.ImemData, pc_plus4: next_pc};
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.ImemReq     = (state_q != S_IDLE);
  assign bus.ImemAddr    = addr_q;
  assign bus.InstrValid  = (count_q != '0);
  assign bus.Instruction = bus.InstrValid ? head.instr    : 32'h0;
  assign bus.PCPlus4     = bus.InstrValid ? head.pc_plus4 : 32'h0;
  assign bus.Count       = count_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // Performance counters: words pushed and redirect cycles, wrapping at 2^32.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push)         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.Redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
